// File: rtl/uart_cfg_arbiter_if.sv
// Requester and register-file signals of the UART configuration arbiter.
// The master view belongs to the arbiter; the slave view to requesters and the register file.
interface uart_cfg_arbiter_if;
   logic       req0, req1;
   logic       rd0, rd1;
   logic [3:0] addr0, addr1;
   logic [3:0] wdata0, wdata1;
   logic [1:0] done;
   logic       err;
   logic [3:0] rdata;
   logic       busy;
   logic       rf_valid;
   logic [3:0] rf_addr;
   logic [3:0] rf_data;
   logic       rf_ack;
   logic [3:0] rf_data_out;
   logic       rf_data_out_valid;

   modport master (
      input  req0, req1, rd0, rd1, addr0, addr1, wdata0, wdata1,
      input  rf_ack, rf_data_out, rf_data_out_valid,
      output done, err, rdata, busy, rf_valid, rf_addr, rf_data
   );

   modport slave (
      output req0, req1, rd0, rd1, addr0, addr1, wdata0, wdata1,
      output rf_ack, rf_data_out, rf_data_out_valid,
      input  done, err, rdata, busy, rf_valid, rf_addr, rf_data
   );
endinterface

// File: rtl/uart_cfg_arbiter.sv
// Round-robin two-port arbiter sequencing single accesses to the UART config register file,
// with local rejection of bad accesses and an ack timeout.
module uart_cfg_arbiter #(
   parameter int TIMEOUT = 8
) (
   input logic                 clk_16bd,
   input logic                 rst_n,
   uart_cfg_arbiter_if.master  bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

   state_t           state_q;
   logic             rr_q;
   logic             win_q;
   logic             rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       done_q;
   logic             err_q;
   logic [3:0]       rdata_q;
   logic             busy_q;
   logic             rf_valid_q;
   logic [3:0]       rf_addr_q;
   logic [3:0]       rf_data_q;

   logic             win_d;
   logic             rd_d;
   logic [3:0]       addr_d;
   logic [3:0]       wdata_d;
   logic             reject_d;
   logic [CNT_W-1:0] cnt_d;

   // rr_q names the preferred requester; it only matters when both are asking.
   always_comb begin
      win_d    = (bus.req0 && bus.req1) ? rr_q : bus.req1;
      rd_d     = win_d ? bus.rd1    : bus.rd0;
      addr_d   = win_d ? bus.addr1  : bus.addr0;
      wdata_d  = win_d ? bus.wdata1 : bus.wdata0;
      reject_d = (addr_d < 4'h9) || (addr_d > 4'hC) || (!rd_d && (wdata_d == 4'hF));
      cnt_d    = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_16bd or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         win_q      <= 1'b0;
         rd_q       <= 1'b0;
         cnt_q      <= '0;
         done_q     <= 2'b00;
         err_q      <= 1'b0;
         rdata_q    <= 4'h0;
         busy_q     <= 1'b0;
         rf_valid_q <= 1'b0;
         rf_addr_q  <= 4'h0;
         rf_data_q  <= 4'h0;
      end else begin
         done_q     <= 2'b00;
         rf_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  win_q  <= win_d;
                  rd_q   <= rd_d;
                  busy_q <= 1'b1;
                  if (reject_d) begin
                     state_q <= RESP;
                     done_q  <= {win_d, ~win_d};
                     err_q   <= 1'b1;
                     rdata_q <= 4'h0;
                  end else begin
                     state_q    <= ISSUE;
                     rf_valid_q <= 1'b1;
                     rf_addr_q  <= addr_d;
                     rf_data_q  <= rd_d ? 4'hF : wdata_d;
                  end
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT_ACK;
            end
            WAIT_ACK: begin
               cnt_q <= cnt_d;
               if (bus.rf_ack) begin
                  state_q <= RESP;
                  done_q  <= {win_q, ~win_q};
                  if (rd_q && bus.rf_data_out_valid) begin
                     err_q   <= 1'b0;
                     rdata_q <= bus.rf_data_out;
                  end else begin
                     // A read acked without qualified data is an error; a write just completes.
                     err_q   <= rd_q;
                     rdata_q <= 4'h0;
                  end
               end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                  state_q <= RESP;
                  done_q  <= {win_q, ~win_q};
                  err_q   <= 1'b1;
                  rdata_q <= 4'h0;
               end
            end
            RESP: begin
               rr_q    <= ~win_q;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.rdata    = rdata_q;
   assign bus.busy     = busy_q;
   assign bus.rf_valid = rf_valid_q;
   assign bus.rf_addr  = rf_addr_q;
   assign bus.rf_data  = rf_data_q;
endmodule

// File: tb/tb_uart_cfg_arbiter.sv
// Bench for uart_cfg_arbiter: register-file model plus a reference of grant order,
// rejection rules, latencies and register contents.
module tb_uart_cfg_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   uart_cfg_arbiter_if bus ();

   uart_cfg_arbiter #(.TIMEOUT(8)) dut (
      .clk_16bd (clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   bit         rf_mute;
   bit         rf_no_valid;
   bit         force_ack;
   logic [3:0] rf_mem [16];
   logic [3:0] exp_regs [16];
   bit         exp_rr;

   // Register-file model: acks one cycle after seeing rf_valid.
   initial begin : rf_model
      bit         pend;
      logic [3:0] pdata;
      pend = 1'b0;
      pdata = 4'h0;
      bus.rf_ack = 1'b0;
      bus.rf_data_out = 4'h0;
      bus.rf_data_out_valid = 1'b0;
      for (int i = 0; i < 16; i++) rf_mem[i] = 4'h0;
      forever begin
         @(negedge clk);
         bus.rf_ack            = pend || force_ack;
         bus.rf_data_out_valid = pend && !rf_no_valid;
         bus.rf_data_out       = pend ? pdata : 4'($urandom);
         pend = 1'b0;
         if (bus.rf_valid && !rf_mute) begin
            pend = 1'b1;
            if (bus.rf_data == 4'hF) pdata = rf_mem[bus.rf_addr];
            else begin
               rf_mem[bus.rf_addr] = bus.rf_data;
               pdata = 4'h0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic bit rejected(input bit rd, input logic [3:0] a, input logic [3:0] w);
      return (a < 4'h9) || (a > 4'hC) || (!rd && w == 4'hF);
   endfunction

   task automatic set_req(input bit n, input bit rd, input logic [3:0] a, input logic [3:0] w);
      if (n) begin
         bus.req1 = 1'b1; bus.rd1 = rd; bus.addr1 = a; bus.wdata1 = w;
      end else begin
         bus.req0 = 1'b1; bus.rd0 = rd; bus.addr0 = a; bus.wdata0 = w;
      end
   endtask

   // Waits (bounded) for a done pulse; lat counts negedges after the request was set.
   task automatic wait_done(output logic [1:0] d, output logic e, output logic [3:0] r,
                            output int lat, output int nvalid,
                            output logic [3:0] ra, output logic [3:0] rdat);
      d = 2'b00; e = 1'b0; r = 4'h0; lat = 0; nvalid = 0; ra = 4'h0; rdat = 4'h0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.rf_valid) begin
            nvalid++; ra = bus.rf_addr; rdat = bus.rf_data;
         end
         if (bus.done !== 2'b00) begin
            d = bus.done; e = bus.err; r = bus.rdata; lat = i;
            break;
         end
      end
   endtask

   task automatic drop_reqs();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.done, bus.err, bus.rdata, bus.busy} !== 8'h00) begin
         bad++; $display("FAIL reset_resp got=%b want=%b", {bus.done, bus.err, bus.rdata, bus.busy}, 8'h00);
      end
      total++;
      if ({bus.rf_valid, bus.rf_addr, bus.rf_data} !== 9'h000) begin
         bad++; $display("FAIL reset_rf got=%h want=%h", {bus.rf_valid, bus.rf_addr, bus.rf_data}, 9'h000);
      end
      rst_n = 1'b1;
      exp_rr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      logic [1:0] d; logic e; logic [3:0] r, ra, rdat; int lat, nv;
      set_req(1'b0, 1'b0, 4'hC, 4'h7);
      wait_done(d, e, r, lat, nv, ra, rdat);
      total++;
      if (nv != 1 || ra !== 4'hC || rdat !== 4'h7) begin
         bad++; $display("FAIL wr_issue got n=%0d a=%h d=%h want n=1 a=c d=7", nv, ra, rdat);
      end
      total++;
      if ({d, e, r} !== {2'b01, 1'b0, 4'h0} || lat != 3) begin
         bad++; $display("FAIL wr_done got done=%b err=%b rdata=%h lat=%0d want 01 0 0 3", d, e, r, lat);
      end
      exp_regs[12] = 4'h7; exp_rr = 1'b1;
      drop_reqs();

      set_req(1'b1, 1'b1, 4'hC, 4'h0);
      wait_done(d, e, r, lat, nv, ra, rdat);
      total++;
      if (nv != 1 || ra !== 4'hC || rdat !== 4'hF) begin
         bad++; $display("FAIL rd_issue got n=%0d a=%h d=%h want n=1 a=c d=f", nv, ra, rdat);
      end
      total++;
      if ({d, e, r} !== {2'b10, 1'b0, 4'h7} || lat != 3) begin
         bad++; $display("FAIL rd_done got done=%b err=%b rdata=%h lat=%0d want 10 0 7 3", d, e, r, lat);
      end
      exp_rr = 1'b0;
      drop_reqs();

      rf_no_valid = 1'b1;
      set_req(1'b0, 1'b1, 4'hC, 4'h0);
      wait_done(d, e, r, lat, nv, ra, rdat);
      total++;
      if ({d, e, r} !== {2'b01, 1'b1, 4'h0} || lat != 3) begin
         bad++; $display("FAIL rd_novalid got done=%b err=%b rdata=%h lat=%0d want 01 1 0 3", d, e, r, lat);
      end
      rf_no_valid = 1'b0; exp_rr = 1'b1;
      drop_reqs();
   endtask

   task automatic test_reject();
      logic [1:0] d; logic e; logic [3:0] r, ra, rdat; int lat, nv;
      set_req(1'b0, 1'b1, 4'h3, 4'h0);
      wait_done(d, e, r, lat, nv, ra, rdat);
      total++;
      if ({d, e} !== {2'b01, 1'b1} || lat != 1 || nv != 0) begin
         bad++; $display("FAIL rej_addr got done=%b err=%b lat=%0d rfv=%0d want 01 1 1 0", d, e, lat, nv);
      end
      total++;
      if (bus.busy !== 1'b1) begin
         bad++; $display("FAIL rej_busy got=%b want=1", bus.busy);
      end
      exp_rr = 1'b1;
      drop_reqs();

      set_req(1'b0, 1'b0, 4'hA, 4'hF);
      wait_done(d, e, r, lat, nv, ra, rdat);
      total++;
      if ({d, e} !== {2'b01, 1'b1} || lat != 1 || nv != 0) begin
         bad++; $display("FAIL rej_wrf got done=%b err=%b lat=%0d rfv=%0d want 01 1 1 0", d, e, lat, nv);
      end
      exp_rr = 1'b1;
      drop_reqs();
   endtask

   task automatic test_back_to_back();
      logic [3:0] a [2];
      logic [3:0] w [2];
      bit         rq [2];
      logic [3:0] exp_rd;
      bit         ew;
      int         got, last;
      for (int n = 0; n < 2; n++) begin
         rq[n] = 1'($urandom_range(0, 1));
         a[n]  = 4'(9 + $urandom_range(0, 3));
         w[n]  = 4'($urandom_range(0, 14));
         set_req(1'(n), rq[n], a[n], w[n]);
      end
      got = 0; last = 0;
      for (int c = 1; c <= 60 && got < 4; c++) begin
         @(negedge clk);
         if (bus.done !== 2'b00) begin
            ew = exp_rr;
            exp_rd = rq[ew] ? exp_regs[a[ew]] : 4'h0;
            if (!rq[ew]) exp_regs[a[ew]] = w[ew];
            total++;
            if (bus.done !== {ew, ~ew}) begin
               bad++; $display("FAIL b2b_grant #%0d got=%b want=%b", got, bus.done, {ew, ~ew});
            end
            total++;
            if ({bus.err, bus.rdata} !== {1'b0, exp_rd}) begin
               bad++; $display("FAIL b2b_resp #%0d got err=%b rdata=%h want 0 %h", got, bus.err, bus.rdata, exp_rd);
            end
            if (got > 0) begin
               total++;
               if (c - last != 4) begin
                  bad++; $display("FAIL b2b_gap #%0d got=%0d want=4", got, c - last);
               end
            end
            last = c; got++; exp_rr = ~ew;
            rq[ew] = 1'($urandom_range(0, 1));
            a[ew]  = 4'(9 + $urandom_range(0, 3));
            w[ew]  = 4'($urandom_range(0, 14));
            set_req(ew, rq[ew], a[ew], w[ew]);
         end
      end
      total++;
      if (got != 4) begin
         bad++; $display("FAIL b2b_count got=%0d want=4", got);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      // Let any access already granted finish before the next scenario.
      repeat (6) @(negedge clk);
      if (bus.busy === 1'b0) exp_rr = exp_rr;
   endtask

   task automatic test_random();
      logic [1:0] d; logic e; logic [3:0] r, ra, rdat; int lat, nv;
      bit n, rdb, rej, xerr;
      logic [3:0] a, w, xr;
      for (int k = 0; k < 24; k++) begin
         n   = 1'($urandom_range(0, 1));
         rdb = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(9 + $urandom_range(0, 3));
         w   = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
         rf_no_valid = rdb && ($urandom_range(0, 4) == 0);
         rej  = rejected(rdb, a, w);
         xerr = rej || (rdb && rf_no_valid);
         xr   = (!xerr && rdb) ? exp_regs[a] : 4'h0;
         if (!rej && !rdb) exp_regs[a] = w;
         set_req(n, rdb, a, w);
         wait_done(d, e, r, lat, nv, ra, rdat);
         total++;
         if ({d, e, r} !== {n, ~n, xerr, xr} || lat != (rej ? 1 : 3) || nv != (rej ? 0 : 1)) begin
            bad++;
            $display("FAIL rand_%0d got done=%b err=%b rdata=%h lat=%0d rfv=%0d want %b %b %h %0d %0d",
                     k, d, e, r, lat, nv, {n, ~n}, xerr, xr, rej ? 1 : 3, rej ? 0 : 1);
         end
         exp_rr = ~n;
         drop_reqs();
      end
      rf_no_valid = 1'b0;
   endtask

   task automatic test_timeout();
      logic [1:0] d; logic e; logic [3:0] r, ra, rdat; int lat, nv;
      rf_mute = 1'b1;
      set_req(1'b0, 1'b1, 4'hA, 4'h0);
      wait_done(d, e, r, lat, nv, ra, rdat);
      total++;
      if ({d, e, r} !== {2'b01, 1'b1, 4'h0} || lat != 10 || nv != 1) begin
         bad++; $display("FAIL timeout got done=%b err=%b rdata=%h lat=%0d rfv=%0d want 01 1 0 10 1", d, e, r, lat, nv);
      end
      exp_rr = 1'b1;
      bus.req0 = 1'b0;
      force_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (bus.done !== 2'b00 || (i > 0 && bus.busy !== 1'b0)) begin
            bad++; $display("FAIL late_ack cyc=%0d got done=%b busy=%b want 00 0", i, bus.done, bus.busy);
         end
      end
      force_ack = 1'b0;
      rf_mute = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [1:0] d; logic e; logic [3:0] r, ra, rdat; int lat, nv;
      rf_mute = 1'b1;
      set_req(1'b0, 1'b0, 4'hB, 4'h5);
      repeat (3) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1 || bus.rf_addr !== 4'hB) begin
         bad++; $display("FAIL mid_inflight got busy=%b rf_addr=%h want 1 b", bus.busy, bus.rf_addr);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.done, bus.err, bus.rdata, bus.busy, bus.rf_valid, bus.rf_addr, bus.rf_data} !== 17'h0) begin
         bad++; $display("FAIL mid_async got=%h want=0",
                         {bus.done, bus.err, bus.rdata, bus.busy, bus.rf_valid, bus.rf_addr, bus.rf_data});
      end
      bus.req0 = 1'b0; rf_mute = 1'b0; exp_rr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (bus.done !== 2'b00) begin
            bad++; $display("FAIL mid_nodone cyc=%0d got=%b want=00", i, bus.done);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      set_req(1'b1, 1'b1, 4'hC, 4'h0);
      wait_done(d, e, r, lat, nv, ra, rdat);
      total++;
      if ({d, e, r} !== {2'b10, 1'b0, exp_regs[12]} || lat != 3) begin
         bad++; $display("FAIL mid_fresh got done=%b err=%b rdata=%h lat=%0d want 10 0 %h 3", d, e, r, lat, exp_regs[12]);
      end
      drop_reqs();
   endtask

   initial begin
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rd0 = 1'b0; bus.rd1 = 1'b0;
      bus.addr0 = 4'h0; bus.addr1 = 4'h0; bus.wdata0 = 4'h0; bus.wdata1 = 4'h0;
      rf_mute = 1'b0; rf_no_valid = 1'b0; force_ack = 1'b0; exp_rr = 1'b0;
      for (int i = 0; i < 16; i++) exp_regs[i] = 4'h0;
      test_reset();
      test_write_read();
      test_reject();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
